// File: rtl/hsv_core_mem_lsu.sv
// -----------------------------------------------------------------------------
// hsv_core_mem_lsu
//   Load/store execution stage. Takes a decoded memory op plus operands, forms
//   the effective address, builds byte strobes and replicated store data, runs a
//   single data-bus transaction (never more than one in flight), aligns and
//   extends the returned load data, and presents the result to commit.
//   FENCE completes as a no-op without touching the bus.
//
// Configuration macro:
//   HSV_MEM_MISALIGN_TRAP_EN  defined   -> misaligned half/word ops skip the bus and
//                                          complete with a misaligned exception
//                                          (cause 4 load / 6 store).
//                             undefined -> ea low bits are forced to natural
//                                          alignment and the access proceeds.
//
// Ports:
//   clk_core, rst_core_n   core clock, async active-low reset
//   flush                  squash the current op (wins over in_valid/out_ready)
//   in_valid/in_ready      op handshake; in_mem/in_base/in_offset/in_wdata/in_rd_addr
//   req_*                  bus request (word-aligned addr, write, wdata, strb)
//   rsp_valid/rsp_rdata/rsp_error  bus response, one per accepted request
//   out_valid/out_ready    result handshake; out_rd_addr/out_rd_value/
//                          out_exception/out_cause
// -----------------------------------------------------------------------------
package hsv_core_mem_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic      store;        // 1 = store, 0 = load
        mem_size_e size;
        logic      sign_extend;  // loads only
        logic      fence;        // overrides everything else
    } mem_data_t;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

endpackage

module hsv_core_mem_lsu
    import hsv_core_mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int STRB_W = ADDR_W / 8
) (
    input  logic              clk_core,
    input  logic              rst_core_n,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  mem_data_t         in_mem,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] in_offset,
    input  logic [ADDR_W-1:0] in_wdata,
    input  logic [4:0]        in_rd_addr,

    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_wdata,
    output logic [STRB_W-1:0] req_strb,

    input  logic              rsp_valid,
    input  logic [ADDR_W-1:0] rsp_rdata,
    input  logic              rsp_error,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_rd_addr,
    output logic [ADDR_W-1:0] out_rd_value,
    output logic              out_exception,
    output logic [3:0]        out_cause
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RSP   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e state_q, state_d;

    // latched op
    logic              store_q;
    mem_size_e         size_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;      // effective address after alignment handling
    logic [ADDR_W-1:0] wdata_q;     // already lane-replicated
    logic [STRB_W-1:0] strb_q;
    logic [4:0]        rd_q;
    // latched result
    logic [ADDR_W-1:0] value_q;
    logic              exc_q;
    logic [3:0]        cause_q;

    logic              accept;
    logic [ADDR_W-1:0] ea_raw;
    logic [ADDR_W-1:0] ea_acc;
    logic              trap;
    logic [STRB_W-1:0] strb_next;
    logic [ADDR_W-1:0] wdata_next;
    logic [ADDR_W-1:0] lane;
    logic [ADDR_W-1:0] load_val;
    logic              rsp_take;

    assign accept = in_valid & in_ready;
    assign ea_raw = in_base + in_offset;

`ifdef HSV_MEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((in_mem.size == SZ_HALF) & ea_raw[0]) |
                        ((in_mem.size == SZ_WORD) & (ea_raw[1:0] != 2'b00));
    assign ea_acc = ea_raw;
    assign trap   = misaligned & ~in_mem.fence;
`else
    // Silently round down to the natural boundary of the access size.
    always_comb begin
        ea_acc = ea_raw;
        case (in_mem.size)
            SZ_HALF: ea_acc[0]   = 1'b0;
            SZ_WORD: ea_acc[1:0] = 2'b00;
            default: ea_acc      = ea_raw;
        endcase
    end
    assign trap = 1'b0;
`endif

    always_comb begin
        strb_next  = {STRB_W{1'b1}};
        wdata_next = in_wdata;
        case (in_mem.size)
            SZ_BYTE: begin
                strb_next  = STRB_W'(4'b0001) << ea_acc[1:0];
                wdata_next = {(ADDR_W/8){in_wdata[7:0]}};
            end
            SZ_HALF: begin
                strb_next  = STRB_W'(4'b0011) << ea_acc[1:0];
                wdata_next = {(ADDR_W/16){in_wdata[15:0]}};
            end
            default: begin
                strb_next  = {STRB_W{1'b1}};
                wdata_next = in_wdata;
            end
        endcase
    end

    // Load alignment: bring the addressed byte lane down to bit 0.
    assign lane = rsp_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (size_q)
            SZ_BYTE: load_val = sext_q ? {{(ADDR_W-8){lane[7]}}, lane[7:0]}
                                       : {{(ADDR_W-8){1'b0}}, lane[7:0]};
            SZ_HALF: load_val = sext_q ? {{(ADDR_W-16){lane[15]}}, lane[15:0]}
                                       : {{(ADDR_W-16){1'b0}}, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    assign rsp_take = (state_q == S_RSP) & rsp_valid & ~flush;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (in_mem.fence | trap) ? S_DONE : S_REQ;
            S_REQ: begin
                if (flush)          state_d = S_IDLE;   // request dropped before acceptance
                else if (req_ready) state_d = S_RSP;
            end
            S_RSP: begin
                // A response arriving with the flush is already the one owed,
                // so there is nothing left to drain.
                if (flush)          state_d = rsp_valid ? S_IDLE : S_DRAIN;
                else if (rsp_valid) state_d = S_DONE;
            end
            S_DRAIN: if (rsp_valid)           state_d = S_IDLE;
            S_DONE:  if (flush | out_ready)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready      = 1'b0;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_write     = 1'b0;
        req_wdata     = '0;
        req_strb      = '0;
        out_valid     = 1'b0;
        out_rd_addr   = '0;
        out_rd_value  = '0;
        out_exception = 1'b0;
        out_cause     = '0;
        case (state_q)
            S_IDLE: in_ready = ~flush;
            S_REQ: begin
                req_valid = 1'b1;
                req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                req_write = store_q;
                req_wdata = wdata_q;
                req_strb  = strb_q;
            end
            S_DONE: begin
                out_valid     = 1'b1;
                out_rd_addr   = rd_q;
                out_rd_value  = value_q;
                out_exception = exc_q;
                out_cause     = cause_q;
            end
            default: ;
        endcase
    end

    // ---------------- op / result registers ----------------
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            store_q <= 1'b0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rd_q    <= '0;
            value_q <= '0;
            exc_q   <= 1'b0;
            cause_q <= '0;
        end else if (accept) begin
            store_q <= in_mem.store;
            size_q  <= in_mem.size;
            sext_q  <= in_mem.sign_extend;
            addr_q  <= ea_acc;
            wdata_q <= wdata_next;
            strb_q  <= strb_next;
            rd_q    <= (in_mem.store | in_mem.fence) ? 5'd0 : in_rd_addr;
            value_q <= '0;
            exc_q   <= trap;
            cause_q <= trap ? (in_mem.store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN) : 4'd0;
        end else if (rsp_take) begin
            if (rsp_error) begin
                value_q <= '0;
                exc_q   <= 1'b1;
                cause_q <= store_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
            end else begin
                value_q <= store_q ? '0 : load_val;
            end
        end
    end

endmodule

// File: tb/tb_hsv_core_mem_lsu.sv
module tb_hsv_core_mem_lsu;
    import hsv_core_mem_lsu_pkg::*;

    logic        clk_core, rst_core_n, flush;
    logic        in_valid, in_ready;
    mem_data_t   in_mem;
    logic [31:0] in_base, in_offset, in_wdata;
    logic [4:0]  in_rd_addr;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic        out_valid, out_ready, out_exception;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_rd_value;
    logic [3:0]  out_cause;

    int checks = 0;
    int errors = 0;

    hsv_core_mem_lsu dut (
        .clk_core(clk_core), .rst_core_n(rst_core_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_mem(in_mem),
        .in_base(in_base), .in_offset(in_offset), .in_wdata(in_wdata),
        .in_rd_addr(in_rd_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd_addr(out_rd_addr),
        .out_rd_value(out_rd_value), .out_exception(out_exception), .out_cause(out_cause)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    typedef struct {
        mem_data_t   mem;
        logic [31:0] base, off, wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        err;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_write;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [4:0]  exp_rd;
        logic [31:0] exp_val;
        logic        exp_exc;
        logic [3:0]  exp_cause;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    function automatic mem_data_t mk(input logic st, input mem_size_e sz,
                                     input logic sx, input logic fe);
        mem_data_t m;
        m.store = st; m.size = sz; m.sign_extend = sx; m.fence = fe;
        return m;
    endfunction

    function automatic vec_t mkv(
        input mem_data_t m, input logic [31:0] base, input logic [31:0] off,
        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
        input logic err, input logic ereq, input logic [31:0] eaddr,
        input logic ewr, input logic [3:0] estrb, input logic [31:0] ewd,
        input logic [4:0] erd, input logic [31:0] eval, input logic eexc,
        input logic [3:0] ecause);
        vec_t v;
        v.mem = m; v.base = base; v.off = off; v.wdata = wd; v.rd = rd;
        v.rdata = rdata; v.err = err; v.exp_req = ereq; v.exp_addr = eaddr;
        v.exp_write = ewr; v.exp_strb = estrb; v.exp_wdata = ewd; v.exp_rd = erd;
        v.exp_val = eval; v.exp_exc = eexc; v.exp_cause = ecause;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one op starting at posedge+1; bus and commit are ready.
    task automatic run_vec(input int idx, input vec_t v);
        int  n;
        bit  seen_req;
        seen_req  = 1'b0;
        in_valid  = 1'b1;
        in_mem    = v.mem;
        in_base   = v.base;
        in_offset = v.off;
        in_wdata  = v.wdata;
        in_rd_addr = v.rd;
        @(negedge clk_core);
        chk("in_ready", idx, 32'(in_ready), 32'd1);
        @(posedge clk_core); #1;
        in_valid = 1'b0;
        if (v.exp_req) begin
            @(negedge clk_core);
            n = 0;
            while (!req_valid && n < 20) begin @(negedge clk_core); n++; end
            chk("req_valid", idx, 32'(req_valid), 32'd1);
            chk("req_latency", idx, 32'(n), 32'd0);
            chk("req_addr", idx, req_addr, v.exp_addr);
            chk("req_write", idx, 32'(req_write), 32'(v.exp_write));
            chk("req_strb", idx, 32'(req_strb), 32'(v.exp_strb));
            chk("req_wdata", idx, req_wdata, v.exp_wdata);
            @(posedge clk_core); #1;
            rsp_valid = 1'b1; rsp_rdata = v.rdata; rsp_error = v.err;
            @(negedge clk_core);
            chk("out_valid_early", idx, 32'(out_valid), 32'd0);
            @(posedge clk_core); #1;
            rsp_valid = 1'b0; rsp_error = 1'b0; rsp_rdata = '0;
        end
        @(negedge clk_core);
        n = 0;
        while (!out_valid && n < 20) begin
            if (req_valid) seen_req = 1'b1;
            @(negedge clk_core); n++;
        end
        if (!v.exp_req) chk("no_bus_req", idx, 32'(seen_req | req_valid), 32'd0);
        chk("out_valid", idx, 32'(out_valid), 32'd1);
        chk("out_latency", idx, 32'(n), 32'd0);
        chk("out_rd_addr", idx, 32'(out_rd_addr), 32'(v.exp_rd));
        chk("out_rd_value", idx, out_rd_value, v.exp_val);
        chk("out_exception", idx, 32'(out_exception), 32'(v.exp_exc));
        chk("out_cause", idx, 32'(out_cause), 32'(v.exp_cause));
        @(posedge clk_core); #1;
    endtask

    task automatic issue(input mem_data_t m, input logic [31:0] base,
                         input logic [31:0] wd, input logic [4:0] rd);
        in_valid = 1'b1; in_mem = m; in_base = base; in_offset = '0;
        in_wdata = wd; in_rd_addr = rd;
        @(posedge clk_core); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_core_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mem = '0;
        in_base = '0; in_offset = '0; in_wdata = '0; in_rd_addr = '0;
        req_ready = 1'b1; rsp_valid = 1'b0; rsp_rdata = '0; rsp_error = 1'b0;
        out_ready = 1'b1;

        // lb, lhu, sb, lw@0x4002, lh, lbu, sh, lw fault, wrap, fence, sw@0x8001
        vecs[0]  = mkv(mk(0, SZ_BYTE, 1, 0), 32'h1000, 32'd3, 0, 5'd5, 32'h8000_0000, 0,
                       1, 32'h1000, 0, 4'b1000, 0, 5'd5, 32'hFFFF_FF80, 0, 0);
        vecs[1]  = mkv(mk(0, SZ_HALF, 0, 0), 32'h2000, 32'd2, 0, 5'd6, 32'hBEEF_1234, 0,
                       1, 32'h2000, 0, 4'b1100, 0, 5'd6, 32'h0000_BEEF, 0, 0);
        vecs[2]  = mkv(mk(1, SZ_BYTE, 0, 0), 32'h3000, 32'd1, 32'h1234_56AB, 5'd9, 0, 0,
                       1, 32'h3000, 1, 4'b0010, 32'hABAB_ABAB, 5'd0, 0, 0, 0);
`ifdef HSV_MEM_MISALIGN_TRAP_EN
        vecs[3]  = mkv(mk(0, SZ_WORD, 0, 0), 32'h4000, 32'd2, 0, 5'd7, 32'hCAFE_F00D, 0,
                       0, 0, 0, 0, 0, 5'd7, 32'h0, 1, 4'd4);
        vecs[10] = mkv(mk(1, SZ_WORD, 0, 0), 32'h8000, 32'd1, 32'h5555_AAAA, 5'd2, 0, 0,
                       0, 0, 0, 0, 0, 5'd0, 32'h0, 1, 4'd6);
`else
        vecs[3]  = mkv(mk(0, SZ_WORD, 0, 0), 32'h4000, 32'd2, 0, 5'd7, 32'hCAFE_F00D, 0,
                       1, 32'h4000, 0, 4'b1111, 0, 5'd7, 32'hCAFE_F00D, 0, 0);
        vecs[10] = mkv(mk(1, SZ_WORD, 0, 0), 32'h8000, 32'd1, 32'h5555_AAAA, 5'd2, 0, 0,
                       1, 32'h8000, 1, 4'b1111, 32'h5555_AAAA, 5'd0, 32'h0, 0, 0);
`endif
        vecs[4]  = mkv(mk(0, SZ_HALF, 1, 0), 32'h5002, 32'hFFFF_FFFE, 0, 5'd8, 32'h0000_8001, 0,
                       1, 32'h5000, 0, 4'b0011, 0, 5'd8, 32'hFFFF_8001, 0, 0);
        vecs[5]  = mkv(mk(0, SZ_BYTE, 0, 0), 32'h6000, 32'd2, 0, 5'd10, 32'h00A5_0000, 0,
                       1, 32'h6000, 0, 4'b0100, 0, 5'd10, 32'h0000_00A5, 0, 0);
        vecs[6]  = mkv(mk(1, SZ_HALF, 0, 0), 32'h7000, 32'd2, 32'hDEAD_BEEF, 5'd11, 0, 0,
                       1, 32'h7000, 1, 4'b1100, 32'hBEEF_BEEF, 5'd0, 0, 0, 0);
        vecs[7]  = mkv(mk(0, SZ_WORD, 1, 0), 32'h9000, 32'd0, 0, 5'd12, 32'h1111_1111, 1,
                       1, 32'h9000, 0, 4'b1111, 0, 5'd12, 32'h0, 1, 4'd5);
        vecs[8]  = mkv(mk(0, SZ_WORD, 0, 0), 32'hFFFF_FFFF, 32'd1, 0, 5'd13, 32'h0BAD_CAFE, 0,
                       1, 32'h0000_0000, 0, 4'b1111, 0, 5'd13, 32'h0BAD_CAFE, 0, 0);
        vecs[9]  = mkv(mk(0, SZ_WORD, 0, 1), 32'hA000, 32'd0, 0, 5'd14, 0, 0,
                       0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 0);

        // reset state
        @(negedge clk_core);
        chk("rst_req_valid", 0, 32'(req_valid), 32'd0);
        chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
        chk("rst_req_addr", 0, req_addr, 32'd0);
        chk("rst_out_value", 0, out_rd_value, 32'd0);
        @(posedge clk_core); #1;
        rst_core_n = 1'b1;
        @(posedge clk_core); #1;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // stalled sw with bus error, commit back-pressure
        req_ready = 1'b0;
        issue(mk(1, SZ_WORD, 0, 0), 32'hA004, 32'h1122_3344, 5'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_core);
            chk("stall_req_valid", k, 32'(req_valid), 32'd1);
            chk("stall_req_addr", k, req_addr, 32'hA004);
            chk("stall_req_wdata", k, req_wdata, 32'h1122_3344);
            chk("stall_req_strb", k, 32'(req_strb), 32'hF);
            @(posedge clk_core); #1;
        end
        req_ready = 1'b1;
        @(negedge clk_core);
        chk("stall_req_held", 0, 32'(req_valid), 32'd1);
        @(posedge clk_core); #1;
        rsp_valid = 1'b1; rsp_error = 1'b1; out_ready = 1'b0;
        @(posedge clk_core); #1;
        rsp_valid = 1'b0; rsp_error = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_core);
            chk("bp_out_valid", k, 32'(out_valid), 32'd1);
            chk("bp_exception", k, 32'(out_exception), 32'd1);
            chk("bp_cause", k, 32'(out_cause), 32'd7);
            chk("bp_rd_addr", k, 32'(out_rd_addr), 32'd0);
            chk("bp_rd_value", k, out_rd_value, 32'd0);
            @(posedge clk_core); #1;
        end
        out_ready = 1'b1;
        @(negedge clk_core);
        chk("bp_release_valid", 0, 32'(out_valid), 32'd1);
        @(posedge clk_core); #1;
        @(negedge clk_core);
        chk("bp_done_idle", 0, 32'(out_valid), 32'd0);
        chk("bp_in_ready", 0, 32'(in_ready), 32'd1);
        @(posedge clk_core); #1;

        // flush in RSP -> DRAIN, response discarded, then fence
        issue(mk(0, SZ_WORD, 0, 0), 32'hB000, 0, 5'd4);
        @(posedge clk_core); #1;          // request accepted, now RSP
        flush = 1'b1;
        @(negedge clk_core);
        chk("rsp_flush_in_ready", 0, 32'(in_ready), 32'd0);
        @(posedge clk_core); #1;
        flush = 1'b0;
        @(negedge clk_core);
        chk("drain_in_ready", 0, 32'(in_ready), 32'd0);
        chk("drain_out_valid", 0, 32'(out_valid), 32'd0);
        chk("drain_req_valid", 0, 32'(req_valid), 32'd0);
        @(posedge clk_core); #1;
        rsp_valid = 1'b1; rsp_rdata = 32'h1234_5678;
        @(posedge clk_core); #1;
        rsp_valid = 1'b0;
        @(negedge clk_core);
        chk("drain_discard_valid", 0, 32'(out_valid), 32'd0);
        chk("drain_back_idle", 0, 32'(in_ready), 32'd1);
        @(posedge clk_core); #1;
        issue(mk(0, SZ_WORD, 0, 1), 32'h0, 0, 5'd9);
        @(negedge clk_core);
        chk("fence_out_valid", 0, 32'(out_valid), 32'd1);
        chk("fence_rd_addr", 0, 32'(out_rd_addr), 32'd0);
        chk("fence_req_valid", 0, 32'(req_valid), 32'd0);
        @(posedge clk_core); #1;

        // flush in REQ drops the request
        req_ready = 1'b0;
        issue(mk(0, SZ_WORD, 0, 0), 32'hC000, 0, 5'd4);
        flush = 1'b1;
        @(negedge clk_core);
        chk("req_flush_pending", 0, 32'(req_valid), 32'd1);
        @(posedge clk_core); #1;
        flush = 1'b0; req_ready = 1'b1;
        @(negedge clk_core);
        chk("req_flush_dropped", 0, 32'(req_valid), 32'd0);
        chk("req_flush_idle", 0, 32'(in_ready), 32'd1);

        // flush wins over in_valid in IDLE
        @(posedge clk_core); #1;
        flush = 1'b1;
        in_valid = 1'b1; in_mem = mk(0, SZ_WORD, 0, 1);
        @(negedge clk_core);
        chk("flush_blocks_ready", 0, 32'(in_ready), 32'd0);
        @(posedge clk_core); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk_core);
        chk("flush_no_accept", 0, 32'(out_valid), 32'd0);
        @(posedge clk_core); #1;

        // reset mid-transaction, late response ignored
        issue(mk(0, SZ_WORD, 0, 0), 32'hD000, 0, 5'd4);
        @(posedge clk_core); #1;          // now RSP
        rst_core_n = 1'b0;
        @(negedge clk_core);
        chk("midrst_req_valid", 0, 32'(req_valid), 32'd0);
        chk("midrst_in_ready", 0, 32'(in_ready), 32'd1);
        @(posedge clk_core); #1;
        rst_core_n = 1'b1;
        rsp_valid = 1'b1; rsp_rdata = 32'hFFFF_FFFF;
        @(posedge clk_core); #1;
        rsp_valid = 1'b0;
        @(negedge clk_core);
        chk("midrst_late_rsp", 0, 32'(out_valid), 32'd0);
        chk("midrst_idle", 0, 32'(in_ready), 32'd1);
        @(posedge clk_core); #1;
        run_vec(100, vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
